// File: rtl/hamming1511_decode_arb_pkg.sv
// Shared constants and state type for the two-port Hamming(15,11) decode arbiter.
package hamming1511_decode_arb_pkg;

  localparam int unsigned CODE_W    = 15;
  localparam int unsigned DATA_W    = 11;
  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned SYN_W     = 4;

  // Response register occupancy
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/hamming1511_decode_arb_if.sv
// Request/response handshake bundle between a codeword source/sink and the decode arbiter.
interface hamming1511_decode_arb_if;
  import hamming1511_decode_arb_pkg::*;

  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] req_ready;
  logic [CODE_W-1:0]    req_code0;
  logic [CODE_W-1:0]    req_code1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_data;
  logic                 rsp_err;
  logic                 rsp_src;

  // Environment side: offers codewords, sinks responses
  modport master (
    output req_valid, req_code0, req_code1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_src
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_code0, req_code1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_src
  );

endinterface

// File: rtl/hamming1511_decoder.sv
// Combinational Hamming(15,11) single-error-correcting decoder.
// Codeword bit k holds Hamming position k+1; parity sits at positions 1,2,4,8.
module hamming1511_decoder
  import hamming1511_decode_arb_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err
);

  logic [SYN_W-1:0] w_syn;

  // Syndrome is the XOR of the positions of all set bits
  always_comb begin
    w_syn = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (i_code[i]) w_syn = w_syn ^ SYN_W'(i + 1);
    end
  end

  // Extract data bits, flipping the one the syndrome points at (if any)
  always_comb begin
    o_data[0]  = i_code[2]  ^ (w_syn == 4'd3);
    o_data[1]  = i_code[4]  ^ (w_syn == 4'd5);
    o_data[2]  = i_code[5]  ^ (w_syn == 4'd6);
    o_data[3]  = i_code[6]  ^ (w_syn == 4'd7);
    o_data[4]  = i_code[8]  ^ (w_syn == 4'd9);
    o_data[5]  = i_code[9]  ^ (w_syn == 4'd10);
    o_data[6]  = i_code[10] ^ (w_syn == 4'd11);
    o_data[7]  = i_code[11] ^ (w_syn == 4'd12);
    o_data[8]  = i_code[12] ^ (w_syn == 4'd13);
    o_data[9]  = i_code[13] ^ (w_syn == 4'd14);
    o_data[10] = i_code[14] ^ (w_syn == 4'd15);
  end

  assign o_err = |w_syn;

endmodule

// File: rtl/hamming1511_decode_arb.sv
// Two-port round-robin arbiter in front of one shared Hamming(15,11) decoder, with a single
// registered response slot and saturating per-port error counters.
module hamming1511_decode_arb
  import hamming1511_decode_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming1511_decode_arb_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     err_cnt0,
  output logic [CNT_W-1:0]     err_cnt1
);

  rsp_state_e        r_state;
  logic              r_last;   // port index of the last accepted transfer
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic              r_src;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic [NUM_PORTS-1:0] w_grant;
  logic [NUM_PORTS-1:0] w_ready;
  logic                 w_slot_open;
  logic                 w_xfer;
  logic                 w_sel;
  logic [CODE_W-1:0]    w_code;
  logic [DATA_W-1:0]    w_dec_data;
  logic                 w_dec_err;

  // Round-robin grant from req_valid and pointer only, so ready never loops back into valid
  always_comb begin
    w_grant = '0;
    case (bus.req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
      default: w_grant = '0;
    endcase
  end

  // Ready is gated by rst_n so nothing is offered while reset is held
  assign w_slot_open   = (r_state == StEmpty) | bus.rsp_ready;
  assign w_ready       = w_grant & {NUM_PORTS{w_slot_open & rst_n}};
  assign bus.req_ready = w_ready;
  assign w_xfer        = |(bus.req_valid & w_ready);
  assign w_sel         = w_grant[1];
  assign w_code        = w_sel ? bus.req_code1 : bus.req_code0;

  hamming1511_decoder u_decoder (
    .i_code (w_code),
    .o_data (w_dec_data),
    .o_err  (w_dec_err)
  );

  // Response slot FSM: load on transfer, drain on consume without a refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_last  <= 1'b1;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_src   <= 1'b0;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_xfer) begin
            r_state <= StFull;
            r_data  <= w_dec_data;
            r_err   <= w_dec_err;
            r_src   <= w_sel;
            r_last  <= w_sel;
          end
        end
        StFull: begin
          if (w_xfer) begin
            r_data  <= w_dec_data;
            r_err   <= w_dec_err;
            r_src   <= w_sel;
            r_last  <= w_sel;
          end else if (bus.rsp_ready) begin
            r_state <= StEmpty;
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  // Saturating error counters; a clear overrides any same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_xfer && w_dec_err) begin
      if (!w_sel && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_sel && (r_cnt1 != '1))  r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign bus.rsp_valid = (r_state == StFull);
  assign bus.rsp_data  = r_data;
  assign bus.rsp_err   = r_err;
  assign bus.rsp_src   = r_src;
  assign err_cnt0      = r_cnt0;
  assign err_cnt1      = r_cnt1;

endmodule

// File: tb/tb_hamming1511_decode_arb.sv
// Directed bench for hamming1511_decode_arb: vector table plus hand-written multi-cycle sequences.
module tb_hamming1511_decode_arb;

  localparam int unsigned CW = 2;
  localparam int NV = 12;

  logic clk;
  logic rst_n;
  logic cnt_clr;
  logic [CW-1:0] err_cnt0;
  logic [CW-1:0] err_cnt1;

  int n_checks;
  int n_errors;

  hamming1511_decode_arb_if bus ();

  hamming1511_decode_arb #(
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .err_cnt0 (err_cnt0),
    .err_cnt1 (err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [14:0] c0;
    logic [14:0] c1;
    logic        rr;
    logic        clr;
    logic [1:0]  exp_ready;
    logic        chk_rsp;
    logic        exp_valid;
    logic [10:0] exp_data;
    logic        exp_err;
    logic        exp_src;
    logic [1:0]  exp_cnt0;
    logic [1:0]  exp_cnt1;
  } vec_t;

  vec_t vec[NV];

  // Independent encoder: data fills non-power-of-two positions, parity makes each group even
  function automatic logic [14:0] enc(input logic [10:0] d);
    logic [14:0] c;
    int j;
    logic p;
    c = '0;
    j = 0;
    for (int b = 0; b < 15; b++) begin
      if (((b + 1) & b) != 0) begin
        c[b] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int b = 0; b < 15; b++) begin
        if ((((b + 1) >> k) & 1) == 1) p = p ^ c[b];
      end
      c[(1 << k) - 1] = p;
    end
    return c;
  endfunction

  function automatic vec_t mk(input logic [1:0] valid, input logic [14:0] c0,
                              input logic [14:0] c1, input logic rr, input logic clr,
                              input logic [1:0] exp_ready, input logic chk_rsp,
                              input logic exp_valid, input logic [10:0] exp_data,
                              input logic exp_err, input logic exp_src,
                              input logic [1:0] exp_cnt0, input logic [1:0] exp_cnt1);
    vec_t v;
    v.valid = valid; v.c0 = c0; v.c1 = c1; v.rr = rr; v.clr = clr;
    v.exp_ready = exp_ready; v.chk_rsp = chk_rsp; v.exp_valid = exp_valid;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_src = exp_src;
    v.exp_cnt0 = exp_cnt0; v.exp_cnt1 = exp_cnt1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    vec[0]  = mk(2'b01, 15'h0000, 15'h0000, 1, 0, 2'b01, 1, 1, 11'h000, 0, 0, 2'd0, 2'd0);
    vec[1]  = mk(2'b10, 15'h0000, 15'h0004, 1, 0, 2'b10, 1, 1, 11'h000, 1, 1, 2'd0, 2'd1);
    vec[2]  = mk(2'b10, 15'h0000, 15'h0001, 1, 0, 2'b10, 1, 1, 11'h000, 1, 1, 2'd0, 2'd2);
    vec[3]  = mk(2'b01, enc(11'h5A5) ^ 15'h0200, 15'h0000, 1, 0, 2'b01, 1, 1, 11'h5A5, 1, 0,
                 2'd1, 2'd2);
    vec[4]  = mk(2'b10, 15'h0000, enc(11'h3C3) ^ 15'h0008, 1, 0, 2'b10, 1, 1, 11'h3C3, 1, 1,
                 2'd1, 2'd3);
    vec[5]  = mk(2'b10, 15'h0000, enc(11'h7FF), 1, 0, 2'b10, 1, 1, 11'h7FF, 0, 1, 2'd1, 2'd3);
    vec[6]  = mk(2'b01, enc(11'h001) ^ 15'h4000, 15'h0000, 1, 0, 2'b01, 1, 1, 11'h001, 1, 0,
                 2'd2, 2'd3);
    vec[7]  = mk(2'b00, 15'h0000, 15'h0000, 1, 0, 2'b00, 0, 0, 11'h000, 0, 0, 2'd2, 2'd3);
    vec[8]  = mk(2'b01, enc(11'h123) ^ 15'h0010, 15'h0000, 1, 1, 2'b01, 1, 1, 11'h123, 1, 0,
                 2'd0, 2'd0);
    vec[9]  = mk(2'b11, enc(11'h0AA), enc(11'h155), 0, 0, 2'b00, 1, 1, 11'h123, 1, 0,
                 2'd0, 2'd0);
    vec[10] = mk(2'b11, enc(11'h0AA), enc(11'h155), 1, 0, 2'b10, 1, 1, 11'h155, 0, 1,
                 2'd0, 2'd0);
    vec[11] = mk(2'b11, enc(11'h0AA), enc(11'h155), 1, 0, 2'b01, 1, 1, 11'h0AA, 0, 0,
                 2'd0, 2'd0);

    // Reset state, with both ports requesting to prove ready stays low
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_code0 = enc(11'h111);
    bus.req_code1 = enc(11'h222);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset rsp_src", 32'(bus.rsp_src), 32'd0);
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset err_cnt0", 32'(err_cnt0), 32'd0);
    chk("reset err_cnt1", 32'(err_cnt1), 32'd0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.req_valid = vec[i].valid;
      bus.req_code0 = vec[i].c0;
      bus.req_code1 = vec[i].c1;
      bus.rsp_ready = vec[i].rr;
      cnt_clr = vec[i].clr;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(vec[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(vec[i].exp_valid));
      if (vec[i].chk_rsp) begin
        chk($sformatf("v%0d rsp_data", i), 32'(bus.rsp_data), 32'(vec[i].exp_data));
        chk($sformatf("v%0d rsp_err", i), 32'(bus.rsp_err), 32'(vec[i].exp_err));
        chk($sformatf("v%0d rsp_src", i), 32'(bus.rsp_src), 32'(vec[i].exp_src));
      end
      chk($sformatf("v%0d err_cnt0", i), 32'(err_cnt0), 32'(vec[i].exp_cnt0));
      chk($sformatf("v%0d err_cnt1", i), 32'(err_cnt1), 32'(vec[i].exp_cnt1));
    end
    @(negedge clk);
    cnt_clr = 1'b0;

    // Alternation after reset: both ports valid, one response per cycle
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_valid = 2'b11;
      bus.req_code0 = enc(11'h0F0);
      bus.req_code1 = enc(11'h70F);
      bus.rsp_ready = 1'b1;
      #1;
      chk($sformatf("rr%0d req_ready", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("rr%0d rsp_src", k), 32'(bus.rsp_src), 32'(k % 2));
      chk($sformatf("rr%0d rsp_data", k), 32'(bus.rsp_data),
          (k % 2 == 0) ? 32'h0F0 : 32'h70F);
    end

    // Backpressure: FULL holds, nothing accepted, pointer kept
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_code0 = enc(11'h001);
      bus.req_code1 = enc(11'h002);
      #1;
      chk($sformatf("stall%0d req_ready", k), 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("stall%0d rsp_data", k), 32'(bus.rsp_data), 32'h70F);
      chk($sformatf("stall%0d rsp_src", k), 32'(bus.rsp_src), 32'd1);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    chk("release req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("release rsp_src", 32'(bus.rsp_src), 32'd0);
    chk("release rsp_data", 32'(bus.rsp_data), 32'h001);

    // Counter saturation at 2 bits, then clear against an erroneous transfer
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.req_valid = 2'b01;
      bus.req_code0 = enc(11'(k * 37 + 5)) ^ 15'h0004;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d err_cnt0", k), 32'(err_cnt0), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    @(negedge clk);
    cnt_clr = 1'b1;
    bus.req_code0 = enc(11'h3AB) ^ 15'h0100;
    @(posedge clk);
    #1;
    chk("clr err_cnt0", 32'(err_cnt0), 32'd0);
    chk("clr rsp_data", 32'(bus.rsp_data), 32'h3AB);
    @(negedge clk);
    cnt_clr = 1'b0;
    bus.req_code0 = enc(11'h055) ^ 15'h0002;
    @(posedge clk);
    #1;
    chk("post-clr err_cnt0", 32'(err_cnt0), 32'd1);

    // Asynchronous reset while FULL
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst err_cnt0", 32'(err_cnt0), 32'd0);
    chk("midrst rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("midrst req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_code0 = enc(11'h600);
    bus.req_code1 = enc(11'h00F);
    bus.rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("postrst req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("postrst rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("postrst rsp_src", 32'(bus.rsp_src), 32'd0);
    chk("postrst rsp_data", 32'(bus.rsp_data), 32'h600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hamming1511_decode_arb.md
HAMMING1511_DECODE_ARB -- requirements
Module: hamming1511_decode_arb

Interface
REQ-001 Parameter: CNT_W, default 16, width of each per-port error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-port codeword valid (bit i = port i).
REQ-005 req_ready  output  2  per-port accept; a transfer occurs when req_valid[i] & req_ready[i].
REQ-006 req_code0  input  15  port 0 codeword, layout [p1 p2 d0 p3 d1 d2 d3 p4 d4..d10] at bits 0..14.
REQ-007 req_code1  input  15  port 1 codeword, same layout.
REQ-008 rsp_valid  output  1  response register holds a decoded word.
REQ-009 rsp_ready  input  1  downstream accepts; the response is consumed when rsp_valid & rsp_ready.
REQ-010 rsp_data  output  11  corrected data [d10..d0].
REQ-011 rsp_err  output  1  nonzero syndrome on the source codeword.
REQ-012 rsp_src  output  1  port index that supplied the response.
REQ-013 cnt_clr  input  1  synchronous clear of both error counters.
REQ-014 err_cnt0, err_cnt1  output  CNT_W  saturating error counts per port.

Function
REQ-015 Single shared decoder; at most one codeword SHALL be accepted per cycle.
REQ-016 The block SHALL take a new codeword ("slot open") when rsp_valid=0 or rsp_ready=1.
REQ-017 req_ready[i] SHALL equal grant[i] & slot_open, combinational; grant SHALL depend only on req_valid and the priority pointer, never on rsp_ready through a loop back to req_valid.
REQ-018 Arbitration SHALL be round-robin: only one port valid -> grant that port; both valid -> grant the port not last accepted.
REQ-019 The last-accepted pointer SHALL update only on an actual transfer; a grant without a transfer SHALL leave it unchanged.
REQ-020 Latency: a codeword accepted at edge N SHALL appear on rsp_data/rsp_err/rsp_src with rsp_valid=1 after edge N; throughput is 1 word/cycle when rsp_ready=1.
REQ-021 State machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1). EMPTY -> FULL on transfer. FULL -> FULL on consume with simultaneous transfer (register reloaded), or on no consume. FULL -> EMPTY on consume with no transfer.
REQ-022 In FULL without consume, rsp_data, rsp_err and rsp_src SHALL hold stable and req_ready SHALL be 2'b00.
REQ-023 Correction: a single-bit error at a data position SHALL be flipped back; an error at a parity position (bits 0,1,3,7) SHALL leave data unchanged; both cases SHALL set rsp_err=1.
REQ-024 err_cntI SHALL increment by 1 on each transfer from port I whose codeword has a nonzero syndrome; at 2^CNT_W-1 it SHALL hold.
REQ-025 cnt_clr=1 SHALL zero both counters at the next edge; a simultaneous increment SHALL be discarded (clear wins).
REQ-026 Double-bit errors are out of scope; the block SHALL pass decoder output unmodified.

Reset
REQ-027 While rst_n=0: rsp_valid=0, rsp_data=0, rsp_err=0, rsp_src=0, err_cnt0=err_cnt1=0, pointer set so port 0 wins the first contention; req_ready=2'b00.
REQ-028 Reset asserted mid-operation SHALL discard any held response with no consume or transfer reported; the first transfer after release follows REQ-018 from the reset pointer.

Structure
REQ-029 A shared package SHALL hold the codeword width (15), data width (11), port count (2) and the EMPTY/FULL state enum.
REQ-030 The existing combinational hamming1511_decoder SHALL be instantiated once as the sole sub-module, fed by the granted port's codeword through a 2:1 mux.

Verification
REQ-031 Port 0 sends 15'h0000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=11'h000, rsp_err=0, rsp_src=0, err_cnt0=0.
REQ-032 Port 1 sends 15'h0004 (d0 flipped) -> rsp_data=11'h000, rsp_err=1, rsp_src=1, err_cnt1=1; 15'h0001 (p1 flipped) -> rsp_data=11'h000, rsp_err=1, err_cnt1=2.
REQ-033 After reset, both ports held valid for 4 words with rsp_ready=1 -> rsp_src sequence 0,1,0,1, one response per cycle.
REQ-034 FULL with rsp_ready=0 for 3 cycles while both ports are valid -> outputs stable, req_ready=00, pointer unchanged; on release the next grant continues the alternation.
REQ-035 CNT_W=2, port 0 sends 5 erroneous words -> err_cnt0 reads 1,2,3,3,3; cnt_clr asserted on the cycle of an erroneous transfer -> err_cnt0=0.
REQ-036 rst_n pulsed low while FULL -> rsp_valid=0 and counters 0 immediately; the first contention after release grants port 0.
